ffinv_k4_seq: RTL and testbench

Sequential inverter for GF(2^4), field polynomial x^4 + x + 1. It computes x^-1 = x^14 with one shared FFMul_K4_Q2 multiplier, one multiplication per cycle, behind valid/ready handshakes. It is the GF(2^4) inversion stage of the composite-field SubBytes datapath. It consumes FFMul_K4_Q2 products and feeds the GF(2^8) inversion back-end.

---
 rtl/ffk4_pkg.sv | 16 +
 rtl/ffmul_k4_q2.sv | 24 ++
 rtl/ffinv_k4_seq.sv | 77 +++++++
 tb/tb_ffinv_k4_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ffk4_pkg.sv
// rtl/ffk4_pkg.sv - GF(2^4) field constants and inverter FSM types
package ffk4_pkg;

   localparam logic [4:0] FF_POLY   = 5'b10011;
   localparam int         INV_STEPS = 5;
   localparam int         STEP_W    = 3;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   typedef logic [STEP_W-1:0] step_t;

endpackage

// File: rtl/ffmul_k4_q2.sv
// rtl/ffmul_k4_q2.sv - combinational GF(2^4) multiplier, reduction by FF_POLY
module ffmul_k4_q2
   import ffk4_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] p
);

   logic [6:0] t;

   always_comb begin
      t = '0;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) t = t ^ 7'({3'b000, a} << i);
      end
      // fold the high terms back down, highest degree first
      for (int i = 6; i >= 4; i--) begin
         if (t[i]) t = t ^ 7'({2'b00, FF_POLY} << (i - 4));
      end
      p = t[3:0];
   end

endmodule

// File: rtl/ffinv_k4_seq.sv
// rtl/ffinv_k4_seq.sv - sequential GF(2^4) inverter, a^-1 = a^14 over one shared multiplier
module ffinv_k4_seq
   import ffk4_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_data
);

   state_t     state, state_nxt;
   step_t      step;
   logic [3:0] base, sq, acc;
   logic [3:0] op_a, op_b, prod;
   logic       last_step;

   assign last_step = (step == step_t'(INV_STEPS - 1));
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_data  = acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = CALC;
         CALC: if (last_step) state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // addition chain: a^2, a^3, a^6, a^12, a^14
   always_comb begin
      op_a = acc;
      op_b = acc;
      case (step)
         3'd0: begin op_a = base; op_b = base; end
         3'd1: begin op_a = sq;   op_b = base; end
         3'd4: begin op_a = acc;  op_b = sq;   end
         default: begin op_a = acc; op_b = acc; end
      endcase
   end

   ffmul_k4_q2 u_mul (
      .a (op_a),
      .b (op_b),
      .p (prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step <= '0;
         base <= '0;
         sq   <= '0;
         acc  <= '0;
      end else if (state == IDLE) begin
         if (in_valid) begin
            base <= in_data;
            step <= '0;
         end
      end else if (state == CALC) begin
         if (step == 3'd0) sq  <= prod;
         else              acc <= prod;
         step <= step + 3'd1;
      end
   end

endmodule

// File: tb/tb_ffinv_k4_seq.sv
// tb/tb_ffinv_k4_seq.sv - directed self-checking bench for ffinv_k4_seq
module tb_ffinv_k4_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ffinv_k4_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] p;
      logic [3:0] x;
      p = 4'h0;
      x = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) p = p ^ x;
         x = x[3] ? ({x[2:0], 1'b0} ^ 4'b0011) : {x[2:0], 1'b0};
      end
      return p;
   endfunction

   // returns at the falling edge right after the accepting edge
   task automatic send(input logic [3:0] a);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("in_ready_timeout", 0, 1);
      in_valid = 1'b1;
      in_data  = a;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_result(output logic [3:0] r, output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) check("out_valid_timeout", 0, 1);
      r = out_data;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("hs_in_ready", int'(in_ready), 1);
      check("hs_out_valid", int'(out_valid), 0);
   endtask

   logic [3:0] r;
   int         lat;
   logic [3:0] kin  [4] = '{4'd1, 4'd2, 4'd8, 4'd14};
   logic [3:0] kout [4] = '{4'd1, 4'd9, 4'd15, 4'd3};

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 4'h0;
      out_ready = 1'b0;
      #12;
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // single op, checking sq after the first product
      send(4'd5);
      @(negedge clk);
      check("sq_after_e1", int'(dut.sq), 2);
      wait_result(r, lat);
      check("single_lat", lat + 1, 5);
      check("single_res", int'(r), 11);
      handshake();

      // known inverses, out_ready held high
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(kin[i]);
         wait_result(r, lat);
         check($sformatf("known_lat_%0d", kin[i]), lat, 5);
         check($sformatf("known_res_%0d", kin[i]), int'(r), int'(kout[i]));
         @(negedge clk);
         check($sformatf("known_hs_%0d", kin[i]), int'(in_ready), 1);
      end
      out_ready = 1'b0;

      // exhaustive sweep
      for (int a = 0; a < 16; a++) begin
         send(4'(a));
         wait_result(r, lat);
         check($sformatf("sweep_lat_%0d", a), lat, 5);
         if (a == 0) check("sweep_zero", int'(r), 0);
         else check($sformatf("sweep_prod_%0d", a), int'(ref_mul(r, 4'(a))), 1);
         handshake();
      end

      // backpressure with stray in_valid pulses
      send(4'd14);
      wait_result(r, lat);
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         in_data  = 4'd5;
         @(negedge clk);
         check("bp_out_valid", int'(out_valid), 1);
         check("bp_out_data", int'(out_data), 3);
         check("bp_in_ready", int'(in_ready), 0);
      end
      in_valid = 1'b0;
      handshake();
      send(4'd8);
      wait_result(r, lat);
      check("bp_next_lat", lat, 5);
      check("bp_next_res", int'(r), 15);
      handshake();

      // reset while step == 2
      send(4'd5);
      @(negedge clk);
      @(negedge clk);
      check("mid_step", int'(dut.step), 2);
      rst_n = 1'b0;
      #1;
      check("mid_in_ready", int'(in_ready), 1);
      check("mid_out_valid", int'(out_valid), 0);
      check("mid_out_data", int'(out_data), 0);
      @(negedge clk);
      rst_n = 1'b1;
      send(4'd2);
      wait_result(r, lat);
      check("post_rst_lat", lat, 5);
      check("post_rst_res", int'(r), 9);
      handshake();

      // in_valid held through CALC with a different operand
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 4'd5;
      @(posedge clk);
      @(negedge clk);
      in_data = 4'd8;
      wait_result(r, lat);
      check("ign_lat", lat, 5);
      check("ign_res", int'(r), 11);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("ign_hs_in_ready", int'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      check("ign_accept", int'(in_ready), 0);
      wait_result(r, lat);
      check("ign2_lat", lat, 5);
      check("ign2_res", int'(r), 15);
      handshake();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
